// File: rtl/cnn_pkg.sv
// Shared constants and types for the digit-recognition CNN datapath.
package cnn_pkg;

  localparam int unsigned IMG_W      = 28;
  localparam int unsigned IMG_H      = 28;
  localparam int unsigned IMG_PIX    = IMG_W * IMG_H;
  localparam int unsigned PIX_W      = 8;
  localparam int unsigned IMG_ADDR_W = 10;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FLUSH = 2'd1,
    FULL  = 2'd2
  } img_ld_state_t;

endpackage

// File: rtl/img_loader.sv
// Pixel-stream front end: writes each accepted pixel into both image memory copies and
// hands a complete frame to the CNN. Define IMG_LOADER_BINARIZE_EN to threshold pixels to 0/all-ones.
module img_loader
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_W  = cnn_pkg::IMG_W,
  parameter int unsigned IMG_H  = cnn_pkg::IMG_H,
  parameter int unsigned PIX_W  = cnn_pkg::PIX_W,
  parameter int unsigned ADDR_W = cnn_pkg::IMG_ADDR_W
`ifdef IMG_LOADER_BINARIZE_EN
  ,
  parameter int unsigned THRESH = 128
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PIX_W-1:0]  s_data,
  input  logic              s_last,
  output logic              mem0_we,
  output logic [ADDR_W-1:0] mem0_addr,
  output logic [PIX_W-1:0]  mem0_data,
  output logic              mem1_we,
  output logic [ADDR_W-1:0] mem1_addr,
  output logic [PIX_W-1:0]  mem1_data,
  output logic              img_valid,
  input  logic              img_release,
  output logic              err_short,
  output logic              err_long,
  output logic [7:0]        frame_cnt
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_W * IMG_H - 1);

  img_ld_state_t     r_state;
  logic [ADDR_W-1:0] r_pix_idx;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [PIX_W-1:0]  r_data;
  logic              r_img_valid;
  logic              r_err_short;
  logic              r_err_long;
  logic [7:0]        r_frame_cnt;
  logic [PIX_W-1:0]  w_wdata;

`ifdef IMG_LOADER_BINARIZE_EN
  assign w_wdata = (32'(s_data) >= THRESH) ? '1 : '0;
`else
  assign w_wdata = s_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= LOAD;
      r_pix_idx   <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_img_valid <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_we        <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      case (r_state)
        LOAD: begin
          if (s_valid) begin
            r_we   <= 1'b1;
            r_addr <= r_pix_idx;
            r_data <= w_wdata;
            if (r_pix_idx == LAST_IDX) begin
              r_pix_idx  <= '0;
              r_state    <= FLUSH;
              r_err_long <= ~s_last;
            end else if (s_last) begin
              r_pix_idx   <= '0;
              r_err_short <= 1'b1;
            end else begin
              r_pix_idx <= r_pix_idx + 1'b1;
            end
          end
        end
        FLUSH: r_state <= FULL;
        FULL: begin
          // img_valid is raised one edge after entering FULL so it follows the final
          // memory write; a release is honoured only once the image has been published.
          if (!r_img_valid) begin
            r_img_valid <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 8'd1;
          end else if (img_release) begin
            r_img_valid <= 1'b0;
            r_state     <= LOAD;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign s_ready   = (r_state == LOAD);
  assign mem0_we   = r_we;
  assign mem0_addr = r_addr;
  assign mem0_data = r_data;
  assign mem1_we   = r_we;
  assign mem1_addr = r_addr;
  assign mem1_data = r_data;
  assign img_valid = r_img_valid;
  assign err_short = r_err_short;
  assign err_long  = r_err_long;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: doc/img_loader.md
# img_loader

Writer-side front end of the digit-recognition CNN: accepts a raster pixel stream from the host bridge over a valid/ready handshake and writes each pixel, at the same address and in the same cycle, into both redundant image memory copies (img_mem_0, img_mem_1). After the last write of a complete frame has landed, it raises `img_valid` to start the CNN. It then blocks further input until the CNN releases the image. It also flags malformed frame lengths and counts completed frames.

## Interface
- `IMG_W`, 28, image width in pixels
- `IMG_H`, 28, image height in pixels
- `PIX_W`, 8, pixel width in bits
- `ADDR_W`, 10, image memory address width; must satisfy 2^ADDR_W ≥ IMG_W·IMG_H
- `THRESH`, 128, binarization threshold; used only with the macro below
- `clk`  in  1  single clock; all logic rises on `clk`
- `reset`  in  1  synchronous, active-high reset
- `s_valid`  in  1  pixel present
- `s_ready`  out  1  loader can accept a pixel
- `s_data`  in  PIX_W  pixel value, row-major order
- `s_last`  in  1  marks the final pixel of a frame
- `mem0_we`, `mem1_we`  out  1  write enables for copy 0 and copy 1
- `mem0_addr`, `mem1_addr`  out  ADDR_W  write addresses
- `mem0_data`, `mem1_data`  out  PIX_W  write data
- `img_valid`  out  1  complete image resident in memory
- `img_release`  in  1  single-cycle pulse from the CNN controller: image consumed
- `err_short`  out  1  single-cycle pulse: `s_last` arrived before pixel IMG_W·IMG_H−1
- `err_long`  out  1  single-cycle pulse: pixel IMG_W·IMG_H−1 arrived without `s_last`
- `frame_cnt`  out  8  number of completed frames, wraps modulo 256

## Operation
- States: LOAD, FLUSH, FULL. Reset state is LOAD.
- Reset values: `s_ready`=1 one cycle after reset deasserts; all of the following are 0: `mem*_we`, `mem*_addr`, `mem*_data`, `img_valid`, `err_*`, `frame_cnt`, the address counter `pix_idx`.
- `s_ready` = (state==LOAD). It is decoded from the state register only and never depends on `s_valid`.
- A pixel is accepted when `s_valid && s_ready`. On acceptance:
  - the write outputs for both copies are registered with `we`=1, `addr`=`pix_idx`, `data`=`s_data`;
  - `pix_idx` increments.
- Both copies always carry identical `we`, `addr` and `data` in the same cycle.
- Final pixel accepted (`pix_idx`==IMG_W·IMG_H−1): go to FLUSH, `pix_idx`←0. If `s_last`==0, also pulse `err_long`; the frame is still treated as complete.
- `s_last` accepted with `pix_idx` < last: pulse `err_short`, `pix_idx`←0, stay in LOAD. That pixel is still written. `img_valid` does not assert, and the partial image is overwritten by the next frame.
- FLUSH lasts exactly one cycle, during which the final write is presented. Then go to FULL, set `img_valid`=1 and increment `frame_cnt`.
- FULL: `s_ready`=0, no writes. When `img_release`=1, go to LOAD and clear `img_valid`.
- `img_release` in LOAD or FLUSH is ignored.
- `reset` mid-frame: return to LOAD, `pix_idx`=0. A write already registered is suppressed (`we`=0 in the cycle after reset).

## Timing
- Write latency is 1 cycle: a pixel accepted at edge E appears on `mem*_*` during cycle E..E+1 and is written at edge E+1.
- `img_valid` rises at edge E+2, where E is the edge that accepted the final pixel, so no read can precede the last write.
- `err_*` pulses are visible in the cycle after the offending acceptance and last exactly one cycle.
- Throughput is 1 pixel/cycle; a frame takes IMG_W·IMG_H + 2 cycles to `img_valid`.
- FULL→LOAD: `s_ready` rises the cycle after `img_release` is sampled.

## Configuration
- `IMG_LOADER_BINARIZE_EN` defined: written data = (`s_data` ≥ THRESH) ? {PIX_W{1'b1}} : 0.
- Undefined: `s_data` is written unchanged. Handshake, timing and error behaviour are identical in both builds.

## Structure
- Shared package `cnn_pkg` holds:
  - constants `IMG_W`, `IMG_H`, `IMG_PIX` (= IMG_W·IMG_H), `PIX_W`, `IMG_ADDR_W`;
  - typedef `pix_t` (logic [PIX_W-1:0]);
  - enum `img_ld_state_t` {LOAD, FLUSH, FULL}.
- No sub-module. The counter, FSM and dual-port write register live in `img_loader`.

## Test plan
- 784 back-to-back pixels (values 0..255 repeating), `s_last` on #783:
  - both memories receive identical writes, addr 0..783;
  - `img_valid` rises 2 cycles after the last acceptance;
  - `frame_cnt`=1; no error pulses.
- Random `s_valid` gaps with a full frame: no pixel is lost or duplicated; the written address sequence is exactly 0..783.
- Short frame (`s_last` on pixel #99): `err_short` pulses once and `img_valid` stays 0. The next full frame restarts writes at addr 0 and completes normally.
- Frame with no `s_last` on #783: `err_long` pulses once, `img_valid`=1, `frame_cnt` increments. While in FULL, `s_valid`=1 produces no writes until `img_release`.
- `reset` asserted after pixel #400:
  - next cycle `mem*_we`=0, `s_ready`=1;
  - a fresh frame writes from addr 0 and completes;
  - `frame_cnt` counts only the fresh frame.
- With `IMG_LOADER_BINARIZE_EN`: inputs 127 and 128 write 0x00 and 0xFF respectively.
